// File: rtl/tdm_stim_gen.sv
// Time-multiplexed stimulus generator: per-source pulse trains are summed onto the neuron
// slot being read by the TDM controller and presented, saturated, one cycle later.
module tdm_stim_gen #(
  parameter int unsigned NEURON_COUNT = 500,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned TS_W         = 32,
  localparam int unsigned SLOT_W = (NEURON_COUNT > 1) ? $clog2(NEURON_COUNT) : 1,
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         slot_valid,
  input  logic [SLOT_W-1:0]            slot_id,
  input  logic                         cfg_we,
  input  logic [SRC_W-1:0]             cfg_src,
  input  logic [2:0]                   cfg_field,
  input  logic [31:0]                  cfg_data,
  output logic signed [DATA_WIDTH-1:0] i_stim,
  output logic [TS_W-1:0]              timestep,
  output logic [NUM_SRC-1:0]           src_active
);

  localparam int unsigned SUM_W = DATA_WIDTH + $clog2(NUM_SRC) + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
      {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NEURON_COUNT - 1);

  localparam logic [2:0] FldTarget = 3'd0;
  localparam logic [2:0] FldAmp    = 3'd1;
  localparam logic [2:0] FldStart  = 3'd2;
  localparam logic [2:0] FldPeriod = 3'd3;
  localparam logic [2:0] FldWidth  = 3'd4;
  localparam logic [2:0] FldEnable = 3'd5;

  logic [SLOT_W-1:0]            r_target [NUM_SRC];
  logic signed [DATA_WIDTH-1:0] r_amp    [NUM_SRC];
  logic [TS_W-1:0]              r_start  [NUM_SRC];
  logic [15:0]                  r_period [NUM_SRC];
  logic [15:0]                  r_width  [NUM_SRC];
  logic [15:0]                  r_phase  [NUM_SRC];
  logic [NUM_SRC-1:0]           r_en;
  logic [NUM_SRC-1:0]           r_started;
  logic [TS_W-1:0]              r_timestep;
  logic signed [DATA_WIDTH-1:0] r_stim;

  logic                         w_frame_end;
  logic                         w_slot_ok;
  logic [TS_W-1:0]              w_ts_inc;
  logic [NUM_SRC-1:0]           w_active;
  logic [NUM_SRC-1:0]           w_cfg_hit;
  logic signed [SUM_W-1:0]      w_sum;
  logic signed [DATA_WIDTH-1:0] w_stim_next;

  assign w_slot_ok   = (slot_id <= LAST_SLOT);
  assign w_frame_end = slot_valid && (slot_id == LAST_SLOT);
  assign w_ts_inc    = r_timestep + TS_W'(1);

  always_comb begin
    w_active  = '0;
    w_cfg_hit = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_active[s]  = r_en[s] && r_started[s] && (r_phase[s] < r_width[s]);
      w_cfg_hit[s] = cfg_we && (cfg_field <= FldEnable) && (32'(cfg_src) == s);
    end
  end

  // Sum uses pre-edge activity so a frame_end update only affects the following slots.
  always_comb begin
    w_sum = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_active[s] && (r_target[s] == slot_id)) begin
        w_sum = w_sum + SUM_W'(r_amp[s]);
      end
    end
  end

  always_comb begin
    w_stim_next = '0;
    if (slot_valid && w_slot_ok) begin
      if (w_sum > SAT_MAX) begin
        w_stim_next = SAT_MAX[DATA_WIDTH-1:0];
      end else if (w_sum < SAT_MIN) begin
        w_stim_next = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
        w_stim_next = w_sum[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timestep <= '0;
      r_stim     <= '0;
      r_en       <= '0;
      r_started  <= '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        r_target[s] <= '0;
        r_amp[s]    <= '0;
        r_start[s]  <= '0;
        r_period[s] <= '0;
        r_width[s]  <= '0;
        r_phase[s]  <= '0;
      end
    end else begin
      r_stim <= w_stim_next;
      if (w_frame_end) begin
        r_timestep <= w_ts_inc;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        // A configuration write to a source wins over that source's frame advance.
        if (w_cfg_hit[s]) begin
          case (cfg_field)
            FldTarget: r_target[s] <= cfg_data[SLOT_W-1:0];
            FldAmp:    r_amp[s]    <= cfg_data[DATA_WIDTH-1:0];
            FldStart:  r_start[s]  <= TS_W'(cfg_data);
            FldPeriod: r_period[s] <= cfg_data[15:0];
            FldWidth:  r_width[s]  <= cfg_data[15:0];
            default: begin
              r_en[s]      <= cfg_data[0];
              r_started[s] <= cfg_data[0] && (r_start[s] <= r_timestep);
              r_phase[s]   <= '0;
            end
          endcase
        end else if (w_frame_end) begin
          if (r_en[s] && !r_started[s]) begin
            if (w_ts_inc >= r_start[s]) begin
              r_started[s] <= 1'b1;
              r_phase[s]   <= '0;
            end
          end else if (r_started[s]) begin
            if (r_period[s] == 16'd0) begin
              if (r_phase[s] != 16'hFFFF) begin
                r_phase[s] <= r_phase[s] + 16'd1;
              end
            end else if ((r_phase[s] + 16'd1) == r_period[s]) begin
              r_phase[s] <= '0;
            end else begin
              r_phase[s] <= r_phase[s] + 16'd1;
            end
          end
        end
      end
    end
  end

  assign i_stim     = r_stim;
  assign timestep   = r_timestep;
  assign src_active = w_active;

endmodule

// File: tb/tb_tdm_stim_gen.sv
// Scoreboard bench for tdm_stim_gen: a closed-form pulse-train model predicts every cycle's
// outputs, and a monitor process compares them one cycle after each stimulus.
module tb_tdm_stim_gen;

  localparam int N = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slot_valid = 1'b0;
  logic [8:0]  slot_id = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_src = '0;
  logic [2:0]  cfg_field = '0;
  logic [31:0] cfg_data = '0;
  logic signed [15:0] i_stim;
  logic [31:0] timestep;
  logic [3:0]  src_active;

  always #5 clk = ~clk;

  tdm_stim_gen dut (
    .clk        (clk),
    .rst        (rst),
    .slot_valid (slot_valid),
    .slot_id    (slot_id),
    .cfg_we     (cfg_we),
    .cfg_src    (cfg_src),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .i_stim     (i_stim),
    .timestep   (timestep),
    .src_active (src_active)
  );

  typedef struct {
    logic [15:0] stim;
    logic [31:0] ts;
    logic [3:0]  act;
    int          tpre;
    int          slot;
    bit          sv;
    bit          rec;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mask0 = '0;
  logic [31:0] mask150 = '0;
  logic [31:0] mask300 = '0;

  // Model: a source enabled during timestep te becomes live at T0 = max(te, start) and its
  // phase in timestep t is (t-T0) mod period, or min(t-T0, 0xFFFF) when period is 0.
  int unsigned m_target[4], m_start[4], m_period[4], m_width[4], m_te[4];
  int          m_amp[4];
  bit          m_en[4];
  int unsigned m_ts;

  task automatic m_clear();
    m_ts = 0;
    for (int s = 0; s < 4; s++) begin
      m_target[s] = 0; m_start[s] = 0; m_period[s] = 0; m_width[s] = 0;
      m_te[s] = 0; m_amp[s] = 0; m_en[s] = 0;
    end
  endtask

  function automatic bit m_active(int s, int unsigned t);
    int unsigned t0, k, ph;
    if (!m_en[s]) return 1'b0;
    t0 = (m_start[s] <= m_te[s]) ? m_te[s] : m_start[s];
    if (t < t0) return 1'b0;
    k = t - t0;
    if (m_period[s] == 0) ph = (k > 65535) ? 65535 : k;
    else ph = k % m_period[s];
    return ph < m_width[s];
  endfunction

  function automatic logic [15:0] m_stim(bit sv, int sid);
    int sum = 0;
    if (!sv || sid >= N) return 16'h0;
    for (int s = 0; s < 4; s++) begin
      if (m_active(s, m_ts) && m_target[s] == sid) sum += m_amp[s];
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return 16'(sum);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic step(input bit r, input bit sv, input int sid, input bit we, input int src,
                      input int fld, input logic [31:0] data, input bit rec);
    exp_t e;
    logic signed [15:0] a16;
    @(negedge clk);
    rst = r; slot_valid = sv; slot_id = 9'(sid);
    cfg_we = we; cfg_src = 2'(src); cfg_field = 3'(fld); cfg_data = data;
    e.stim = r ? 16'h0 : m_stim(sv, sid);
    e.tpre = int'(m_ts); e.slot = sid; e.sv = sv; e.rec = rec;
    if (r) begin
      m_clear();
    end else begin
      if (we) begin
        case (fld)
          0: m_target[src] = int'(data[8:0]);
          1: begin a16 = data[15:0]; m_amp[src] = int'(a16); end
          2: m_start[src] = data;
          3: m_period[src] = int'(data[15:0]);
          4: m_width[src] = int'(data[15:0]);
          5: begin m_en[src] = data[0]; m_te[src] = m_ts; end
          default: ;
        endcase
      end
      if (sv && sid == N - 1) m_ts++;
    end
    e.ts = m_ts;
    for (int s = 0; s < 4; s++) e.act[s] = m_active(s, m_ts);
    q.push_back(e);
  endtask

  task automatic slot(input int sid, input bit rec);
    step(0, 1, sid, 0, 0, 0, 0, rec);
  endtask

  task automatic cfg(input int src, input int fld, input logic [31:0] data);
    step(0, 0, 0, 1, src, fld, data, 0);
  endtask

  task automatic rand_cfg_slot(input int sid, input bit rec);
    int opts[5] = '{0, 1, 5, 6, 7};
    int src, fld;
    logic [31:0] d;
    src = $urandom_range(0, 3);
    fld = m_en[src] ? opts[$urandom_range(0, 4)] : $urandom_range(0, 7);
    case (fld)
      0: d = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 3) * 100 + 10);
      1: d = $urandom;
      2: d = 32'($urandom_range(0, 10));
      3: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
      4: d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 7));
      5: d = ($urandom & 32'hFFFF_FFFE) | 32'($urandom_range(0, 3) != 0);
      default: d = $urandom;
    endcase
    step(0, 1, sid, 1, src, fld, d, rec);
  endtask

  task automatic run_frame(input bit rec, input bit rnd_cfg);
    for (int sid = 0; sid < N; sid++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) step(0, 0, $urandom_range(0, N - 1), 0, 0, 0, 0, rec);
        else step(0, 1, $urandom_range(N, 511), 0, 0, 0, 0, rec);
      end
      if (rnd_cfg && sid != N - 1 && $urandom_range(0, 29) == 0) rand_cfg_slot(sid, rec);
      else slot(sid, rec);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("i_stim", 32'($unsigned(i_stim)), 32'(e.stim));
        chk("timestep", timestep, e.ts);
        chk("src_active", 32'(src_active), 32'(e.act));
        if (e.rec && e.sv && i_stim != 16'sd0 && e.tpre < 32) begin
          if (e.slot == 0)   mask0[e.tpre] = 1'b1;
          if (e.slot == 150) mask150[e.tpre] = 1'b1;
          if (e.slot == 300) mask300[e.tpre] = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    m_clear();
    // Reset with a concurrent enable write that must be overridden.
    step(1, 1, 0, 1, 0, 5, 32'h1, 0);
    step(1, 1, 0, 1, 0, 5, 32'h1, 0);
    slot(0, 0);

    // Directed single source, periodic pulse and one-shot, run side by side.
    cfg(0, 0, 0);    cfg(0, 1, 4096); cfg(0, 2, 0); cfg(0, 3, 0); cfg(0, 4, 32'hFFFF);
    cfg(1, 0, 150);  cfg(1, 1, 2048); cfg(1, 2, 3); cfg(1, 3, 5); cfg(1, 4, 2);
    cfg(2, 0, 300);  cfg(2, 1, 32'hFC18); cfg(2, 2, 2); cfg(2, 3, 0); cfg(2, 4, 1);
    cfg(3, 0, 400);  cfg(3, 1, $urandom); cfg(3, 2, $urandom_range(0, 5));
    cfg(3, 3, $urandom_range(0, 6)); cfg(3, 4, $urandom_range(0, 7));
    for (int s = 0; s < 4; s++) cfg(s, 5, 1);
    for (int f = 0; f < 16; f++) run_frame(1, 0);

    // Saturation in both directions, then unsaturated sums.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      cfg(s, 0, 7); cfg(s, 1, 32'h6000); cfg(s, 4, 32'hFFFF); cfg(s, 5, 1);
    end
    slot(7, 0); slot(6, 0); slot(7, 0);
    for (int s = 0; s < 4; s++) cfg(s, 1, 32'hA000);
    slot(7, 0); slot(8, 0);
    cfg(0, 1, 100); cfg(1, 1, 200); cfg(2, 1, 400); cfg(3, 1, 800);
    slot(7, 0);

    // Disable source 1 on the very cycle of frame_end.
    for (int sid = 0; sid < N - 1; sid++) slot(sid, 0);
    step(0, 1, N - 1, 1, 1, 5, 32'h0, 0);
    slot(7, 0); slot(7, 0);

    // slot_valid low, then reset in the middle of a frame.
    step(0, 0, 7, 0, 0, 0, 0, 0);
    for (int sid = 0; sid < 250; sid++) slot(sid, 0);
    step(1, 1, 250, 0, 0, 0, 0, 0);
    for (int sid = 251; sid < N; sid++) slot(sid, 0);
    run_frame(0, 0);

    // Randomized configuration traffic over several frames.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 8; f++) run_frame(0, 1);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    chk("slot0_timesteps", mask0, 32'h0000_FFFF);
    chk("slot150_timesteps", mask150, 32'h0000_6318);
    chk("slot300_timesteps", mask300, 32'h0000_0004);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_stim_gen.md
TDM_STIM_GEN -- requirements
Module: tdm_stim_gen

Interface
REQ-001 SHALL have parameter NEURON_COUNT, default 500, number of time-multiplexed neuron slots per frame.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed stimulus width (Q4.12, 4096 = 1.0).
REQ-003 SHALL have parameter NUM_SRC, default 4, number of independent stimulus sources.
REQ-004 SHALL have parameter TS_W, default 32, timestep counter width.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst  input  1  reset (synchronous, active-high).
REQ-007 SHALL have port slot_valid  input  1  slot_id is valid this cycle.
REQ-008 SHALL have port slot_id  input  clog2(NEURON_COUNT)  neuron currently read by the TDM controller.
REQ-009 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-010 SHALL have port cfg_src  input  clog2(NUM_SRC) (min 1)  source index.
REQ-011 SHALL have port cfg_field  input  3  field select: 0 target, 1 amplitude, 2 start, 3 period, 4 width, 5 enable.
REQ-012 SHALL have port cfg_data  input  32  write data, low bits used per field width.
REQ-013 SHALL have port i_stim  output  DATA_WIDTH  signed stimulus for the slot presented one cycle earlier.
REQ-014 SHALL have port timestep  output  TS_W  completed-frame count.
REQ-015 SHALL have port src_active  output  NUM_SRC  per-source active flag for the current timestep.

Function
REQ-016 SHALL store per source: target (slot_id width), amp (DATA_WIDTH signed), start (TS_W), period (16), width (16), en (1), started (1), phase (16).
REQ-017 SHALL define frame_end = slot_valid && slot_id == NEURON_COUNT-1; timestep increments by 1 on frame_end, wrapping modulo 2^TS_W.
REQ-018 SHALL set started, phase=0 for an enabled, not-started source on frame_end when timestep+1 >= start (unsigned compare).
REQ-019 SHALL on frame_end for a started source: if period==0, phase = min(phase+1, 16'hFFFF) (one-shot); else phase = (phase+1 == period) ? 0 : phase+1.
REQ-020 SHALL define active = en && started && phase < width; src_active reflects it combinationally from registered state.
REQ-021 SHALL write the enable field (cfg_data[0]) to en and clear started/phase, then set started immediately if the new en=1 and start <= timestep.
REQ-022 SHALL apply writes to fields 0-4 immediately, without altering started/phase; field values 6-7 ignored.
REQ-023 SHALL give a same-cycle cfg_we to a source priority over that source's frame_end update (frame_end advance discarded for that source only; timestep still increments).
REQ-024 SHALL register i_stim each cycle: if slot_valid, sum of amp of all active sources with target == slot_id, else 0; latency exactly 1 cycle.
REQ-025 SHALL compute the sum in DATA_WIDTH+clog2(NUM_SRC)+1 bits and saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 SHALL use activity state as held before the current clock edge for the i_stim sum (frame_end updates affect the next slot onward).
REQ-027 SHALL ignore slot_id values >= NEURON_COUNT for frame_end and yield i_stim = 0 for them.

Reset
REQ-028 SHALL on rst clear i_stim, timestep, src_active and all per-source fields and state to 0, overriding cfg_we and slot_valid in the same cycle.
REQ-029 SHALL restart cleanly on rst asserted mid-frame: next frame counting begins from timestep 0 with all sources disabled.

Verification
REQ-030 SHALL verify single source: target=0, amp=4096, start=0, period=0, width=16'hFFFF, en=1; sweep slots 0..499 -> i_stim=4096 one cycle after slot 0, 0 otherwise.
REQ-031 SHALL verify periodic pulse: target=150, amp=2048, start=3, period=5, width=2 -> nonzero at slot 150 only in timesteps 3,4,8,9,13,14.
REQ-032 SHALL verify saturation: 4 sources target=7, amp=16'h6000 -> i_stim=16'h7FFF; amps 16'hA000 each -> 16'h8000.
REQ-033 SHALL verify frame_end coincident with cfg_we enable=0 on source 1 -> source 1 inactive next slot, timestep still increments.
REQ-034 SHALL verify slot_valid=0 -> i_stim=0 next cycle; rst mid-frame at slot 250 -> i_stim=0, timestep=0, src_active=0 next cycle.
REQ-035 SHALL verify one-shot: period=0, width=1, start=2 -> active only in timestep 2.
